tt_um_taghreed_eialsalman_lut_logic_unit: RTL and testbench

//   Programmable successor to the fixed F=(A&B)|~C cell: a 2^N_IN-entry truth-table LUT

---
 rtl/tt_um_taghreed_eialsalman_lut_logic_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_tt_um_taghreed_eialsalman_lut_logic_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_taghreed_eialsalman_lut_logic_unit.sv
// -----------------------------------------------------------------------------
// tt_um_taghreed_eialsalman_lut_logic_unit
//
// Programmable truth-table logic cell for a Tiny Tapeout tile. A 2^N_IN-entry
// LUT evaluates F over the synchronised function inputs. F is registered, its
// rising edges are counted, and the table can be reloaded at run time over a
// bit-serial configuration port (cfg_mode / cfg_strobe / cfg_data).
//
// Optional build macro:
//   LUT_CNT_SAT_EN  - rising-edge counter saturates at 63 instead of wrapping.
//
// ui_in map : [N_IN-1:0] function inputs (A = bit 0), [4] cnt_clr,
//             [5] cfg_data, [6] cfg_strobe, [7] cfg_mode
// uo_out    : [0] F_q, [1] rise pulse, [7:2] rising-edge count
// uio_out   : [0] cfg_loaded (sticky), [1] cfg_busy, [7:2] zero
// -----------------------------------------------------------------------------
module tt_um_taghreed_eialsalman_lut_logic_unit #(
  parameter int          N_IN     = 3,
  parameter logic [15:0] LUT_INIT = 16'h008F,
  parameter int          CNT_W    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Table width and the bit counter value that marks the final shifted bit.
  localparam int         W        = 1 << N_IN;
  localparam logic [3:0] LAST_BIT = 4'(W - 1);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers: every ui_in bit gets its own two-flop chain.
  // ---------------------------------------------------------------------------
  logic [7:0] sync_s;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;

      // Two-stage synchroniser for one input bit, frozen while the tile is disabled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else if (ena) begin
          s1_reg <= ui_in[gi];
          s2_reg <= s1_reg;
        end
      end

      assign sync_s[gi] = s2_reg;
    end
  endgenerate

  // Named views of the synchronised control inputs.
  logic [N_IN-1:0] in_s;
  logic            cnt_clr_s;
  logic            cfg_data_s;
  logic            cfg_strobe_s;
  logic            cfg_mode_s;

  assign in_s         = sync_s[N_IN-1:0];
  assign cnt_clr_s    = sync_s[4];
  assign cfg_data_s   = sync_s[5];
  assign cfg_strobe_s = sync_s[6];
  assign cfg_mode_s   = sync_s[7];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]     lut_reg;
  logic [W-1:0]     shadow_reg;
  logic [3:0]       bitcnt_reg;
  state_t           state_reg;
  logic             busy_reg;
  logic             cfg_loaded_reg;
  logic             stb_prev_reg;
  logic             mode_prev_reg;
  logic             f_q_reg;
  logic             f_prev_reg;
  logic [CNT_W-1:0] cnt_reg;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             lut_bit;
  logic             stb_rise;
  logic             mode_rise;
  logic             f_rise_next;
  logic [W-1:0]     shadow_next;
  logic [CNT_W-1:0] cnt_next;

  // Table lookup, strobe/mode edge detection and the next shadow word.
  always_comb begin
    lut_bit     = lut_reg[in_s];
    stb_rise    = cfg_strobe_s & ~stb_prev_reg;
    mode_rise   = cfg_mode_s & ~mode_prev_reg;
    // F_q is about to go 0->1 on this edge.
    f_rise_next = lut_bit & ~f_q_reg;
    // New bits enter at the LSB, so the first bit shifted ends up as the table MSB.
    shadow_next = {shadow_reg[W-2:0], cfg_data_s};
  end

  // Counter increment: saturating or wrapping depending on the build.
  always_comb begin
`ifdef LUT_CNT_SAT_EN
    if (cnt_reg == {CNT_W{1'b1}}) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
`else
    cnt_next = cnt_reg + CNT_W'(1);
`endif
  end

  // ---------------------------------------------------------------------------
  // Edge-history flops for the strobe and mode inputs.
  // ---------------------------------------------------------------------------

  // Remember last cycle's synced strobe/mode so rising edges can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_prev_reg  <= 1'b0;
      mode_prev_reg <= 1'b0;
    end else if (ena) begin
      stb_prev_reg  <= cfg_strobe_s;
      mode_prev_reg <= cfg_mode_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration FSM. LOAD is entered only on a low->high of cfg_mode, so after
  // a commit the host must drop cfg_mode before another load can begin. A drop
  // of cfg_mode is checked before the strobe, so a simultaneous strobe is lost
  // and the load aborts with the live table untouched.
  // ---------------------------------------------------------------------------

  // Serial table load: shift on strobe edges, commit on the last bit, abort on mode drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      busy_reg       <= 1'b0;
      lut_reg        <= LUT_INIT[W-1:0];
      shadow_reg     <= '0;
      bitcnt_reg     <= '0;
      cfg_loaded_reg <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        RUN: begin
          if (mode_rise) begin
            state_reg  <= LOAD;
            busy_reg   <= 1'b1;
            shadow_reg <= '0;
            bitcnt_reg <= '0;
          end
        end
        LOAD: begin
          if (!cfg_mode_s) begin
            state_reg <= RUN;
            busy_reg  <= 1'b0;
          end else if (stb_rise) begin
            shadow_reg <= shadow_next;
            bitcnt_reg <= bitcnt_reg + 4'd1;
            if (bitcnt_reg == LAST_BIT) begin
              lut_reg        <= shadow_next;
              cfg_loaded_reg <= 1'b1;
              state_reg      <= RUN;
              busy_reg       <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= RUN;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Evaluation datapath. The LUT keeps evaluating with the current table while
  // a load is in progress; a committed table takes effect on the next edge.
  // ---------------------------------------------------------------------------

  // Register F and keep one cycle of history for the rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q_reg    <= 1'b0;
      f_prev_reg <= 1'b0;
    end else if (ena) begin
      f_q_reg    <= lut_bit;
      f_prev_reg <= f_q_reg;
    end
  end

  // Count real 0->1 transitions of F_q; clear has priority over the increment.
  // The increment is taken on the same edge that raises F_q, so the new count
  // appears together with the rising output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (ena) begin
      if (cnt_clr_s) begin
        cnt_reg <= '0;
      end else if (f_rise_next) begin
        cnt_reg <= cnt_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign uo_out  = {cnt_reg, f_q_reg & ~f_prev_reg, f_q_reg};
  assign uio_out = {6'b00_0000, busy_reg, cfg_loaded_reg};
  assign uio_oe  = 8'b0000_0011;

  // Bidirectional inputs and synchronised bits beyond N_IN are intentionally unused.
  logic _unused;
  assign _unused = &{1'b0, uio_in, sync_s[3:0]};

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_lut_logic_unit.sv
// -----------------------------------------------------------------------------
// Bench for tt_um_taghreed_eialsalman_lut_logic_unit.
// Expected values are queued with the cycle they become due and are compared
// on the falling clock edge when that cycle arrives.
// Define LUT_CNT_SAT_EN for both bench and RTL to exercise the saturating counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tt_um_taghreed_eialsalman_lut_logic_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_taghreed_eialsalman_lut_logic_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  localparam int FLD_F    = 0;
  localparam int FLD_RISE = 1;
  localparam int FLD_CNT  = 2;
  localparam int FLD_UIO  = 3;
  localparam int FLD_UO   = 4;
  localparam int FLD_OE   = 5;

  typedef struct {
    int         due;
    string      tag;
    int         fld;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  logic [7:0] tbl_8f = 8'h8F;
  logic [7:0] tbl_96 = 8'h96;

  function automatic logic [7:0] pick(input int fld);
    case (fld)
      FLD_F:    return {7'b0, uo_out[0]};
      FLD_RISE: return {7'b0, uo_out[1]};
      FLD_CNT:  return {2'b0, uo_out[7:2]};
      FLD_UIO:  return uio_out;
      FLD_UO:   return uo_out;
      default:  return uio_oe;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %-12s cyc=%0d got=%02h want=%02h", tag, cyc, obs, exp);
    end else begin
      $display("ok   %-12s cyc=%0d val=%02h", tag, cyc, obs);
    end
  endtask

  task automatic check_due();
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        check_val(sb_q[i].tag, pick(sb_q[i].fld), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  endtask

  task automatic expect_at(input int d, input string tag, input int fld, input logic [7:0] e);
    sb_q.push_back('{cyc + d, tag, fld, e});
  endtask

  task automatic expect_now(input string tag, input int fld, input logic [7:0] e);
    sb_q.push_back('{cyc, tag, fld, e});
    check_due();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      check_due();
    end
  endtask

  task automatic do_reset(input logic [7:0] v);
    ui_in = v;
    rst_n = 1'b0;
    #1;
    expect_now("rst_uo", FLD_UO, 8'h00);
    expect_now("rst_uio", FLD_UIO, 8'h00);
    expect_now("rst_oe", FLD_OE, 8'h03);
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic strobe_bit(input logic b);
    ui_in = 8'hC0 | (b ? 8'h20 : 8'h00);
    tick(2);
    ui_in = 8'h80;
    tick(2);
  endtask

  function automatic logic [7:0] cnt_model(input int edges);
`ifdef LUT_CNT_SAT_EN
    return (edges > 63) ? 8'd63 : 8'(edges);
`else
    return 8'(edges % 64);
`endif
  endfunction

  initial begin
    logic [7:0] bits;
    int guard;

    // Reset state
    do_reset(8'h00);

    // 1. walk all input combinations through the reset table
    for (int v = 0; v < 8; v++) begin
      ui_in = 8'(v);
      expect_at(3, "t1_f", FLD_F, {7'b0, tbl_8f[v]});
      tick(4);
    end

    // 2. five A toggles with B=C=1, then clear
    ui_in = 8'h16; tick(4);
    ui_in = 8'h06; expect_at(3, "t2_cnt0", FLD_CNT, 8'd0); tick(4);
    for (int k = 1; k <= 5; k++) begin
      ui_in = 8'h07;
      expect_at(3, "t2_f1", FLD_F, 8'd1);
      expect_at(3, "t2_rise", FLD_RISE, 8'd1);
      expect_at(4, "t2_rise_off", FLD_RISE, 8'd0);
      expect_at(3, "t2_cnt", FLD_CNT, 8'(k));
      tick(4);
      ui_in = 8'h06;
      expect_at(3, "t2_f0", FLD_F, 8'd0);
      tick(4);
    end
    ui_in = 8'h16;
    expect_at(2, "t2_cnt_pre", FLD_CNT, 8'd5);
    expect_at(3, "t2_cnt_clr", FLD_CNT, 8'd0);
    tick(1);
    ui_in = 8'h06; tick(4);

    // 3. load the parity table 8'h96
    ui_in = 8'h80; expect_at(3, "t3_busy", FLD_UIO, 8'h02); tick(4);
    bits = tbl_96;
    for (int i = 7; i >= 0; i--) strobe_bit(bits[i]);
    expect_now("t3_loaded", FLD_UIO, 8'h01);
    ui_in = 8'h00; expect_at(3, "t3_mode_lo", FLD_UIO, 8'h01); tick(4);
    ui_in = 8'h01; expect_at(3, "t3_f001", FLD_F, {7'b0, tbl_96[1]}); tick(4);
    ui_in = 8'h03; expect_at(3, "t3_f011", FLD_F, {7'b0, tbl_96[3]}); tick(4);
    ui_in = 8'h07; expect_at(3, "t3_f111", FLD_F, {7'b0, tbl_96[7]}); tick(4);

    // 4. aborted load leaves the reset table in place
    do_reset(8'h00);
    ui_in = 8'h80; expect_at(3, "t4_busy", FLD_UIO, 8'h02); tick(4);
    for (int i = 0; i < 4; i++) strobe_bit(1'b1);
    ui_in = 8'h00; expect_at(3, "t4_abort", FLD_UIO, 8'h00); tick(4);
    ui_in = 8'h04; expect_at(3, "t4_f100", FLD_F, {7'b0, tbl_8f[4]}); tick(4);
    ui_in = 8'h03; expect_at(3, "t4_f011", FLD_F, {7'b0, tbl_8f[3]}); tick(4);

    // 5. counter boundary: 65 rising edges
    ui_in = 8'h16; tick(4);
    ui_in = 8'h06; expect_at(3, "t5_cnt0", FLD_CNT, 8'd0); tick(4);
    for (int e = 1; e <= 65; e++) begin
      ui_in = 8'h07;
      if (e >= 62) expect_at(3, "t5_cnt", FLD_CNT, cnt_model(e));
      tick(2);
      ui_in = 8'h06;
      tick(2);
    end

    // 6. reset in the middle of a load
    ui_in = 8'h80; tick(4);
    for (int i = 0; i < 6; i++) strobe_bit(1'b0);
    expect_now("t6_busy", FLD_UIO, 8'h02);
    do_reset(8'h04);
    expect_at(1, "t6_run", FLD_UIO, 8'h00);
    expect_at(3, "t6_f100", FLD_F, {7'b0, tbl_8f[4]});
    tick(4);
    ui_in = 8'h03; expect_at(3, "t6_f011", FLD_F, {7'b0, tbl_8f[3]}); tick(4);

    // ena=0 freezes everything
    ui_in = 8'h16; tick(4);
    ui_in = 8'h06; tick(4);
    for (int k = 1; k <= 3; k++) begin
      ui_in = 8'h07;
      if (k == 3) expect_at(4, "t6_pre_hold", FLD_UO, 8'h0D);
      tick(4);
      if (k < 3) begin
        ui_in = 8'h06;
        tick(4);
      end
    end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ui_in = (i % 2 == 1) ? 8'h07 : 8'h96;
      expect_at(1, "t6_hold_uo", FLD_UO, 8'h0D);
      expect_at(1, "t6_hold_uio", FLD_UIO, 8'h00);
      tick(1);
    end
    ena = 1'b1;
    ui_in = 8'h06;
    expect_at(3, "t6_resume_f", FLD_F, 8'd0);
    expect_at(3, "t6_resume_c", FLD_CNT, 8'd3);
    tick(4);
    ui_in = 8'h07; expect_at(3, "t6_cnt4", FLD_CNT, 8'd4); tick(4);

    // drain anything still pending, bounded
    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      tick(1);
      guard++;
    end
    if (sb_q.size() != 0) check_val("sb_drain", 8'(sb_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
